// File: rtl/bus_arbiter_2.sv
// Two-requester bus arbiter: round-robin on contention, hold-time preemption,
// and a mandatory one-cycle TURN gap between grants to different requesters.
module bus_arbiter_2 #(
  parameter int unsigned MaxHold = 8
) (
  input  logic Clock,
  input  logic nReset,
  input  logic Req_0,
  input  logic Req_1,
  output logic Gnt_0,
  output logic Gnt_1,
  output logic MuxSel,
  output logic MuxEnable,
  output logic Busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    TURN   = 2'd3
  } state_t;

  localparam logic [7:0] HoldLimit = 8'(MaxHold - 1);

  state_t     r_state;
  state_t     w_next;
  logic       r_last_gnt;
  logic [7:0] r_hold_cnt;
  logic       r_gnt0;
  logic       r_gnt1;
  logic       r_mux_sel;
  logic       r_mux_en;
  logic       r_busy;
  logic       w_hold_expired;
  logic       w_entry;
  logic       w_in_grant;

  always_comb begin
    w_next         = r_state;
    w_hold_expired = (r_hold_cnt == HoldLimit);
    case (r_state)
      IDLE, TURN: begin
        if (Req_0 && Req_1)
          w_next = r_last_gnt ? GRANT0 : GRANT1;
        else if (Req_0)
          w_next = GRANT0;
        else if (Req_1)
          w_next = GRANT1;
        else
          w_next = IDLE;
      end
      // A release takes priority, but both release and preemption lead to TURN.
      GRANT0: if (!Req_0 || (w_hold_expired && Req_1)) w_next = TURN;
      GRANT1: if (!Req_1 || (w_hold_expired && Req_0)) w_next = TURN;
      default: w_next = IDLE;
    endcase
  end

  assign w_in_grant = (r_state == GRANT0) || (r_state == GRANT1);
  // GRANTn is only ever entered from IDLE or TURN, so any state change into it is an entry.
  assign w_entry    = ((w_next == GRANT0) || (w_next == GRANT1)) && (w_next != r_state);

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_state    <= IDLE;
      r_last_gnt <= 1'b1;
      r_hold_cnt <= '0;
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_mux_sel  <= 1'b0;
      r_mux_en   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_gnt0   <= (w_next == GRANT0);
      r_gnt1   <= (w_next == GRANT1);
      r_mux_en <= (w_next == GRANT0) || (w_next == GRANT1);
      r_busy   <= (w_next != IDLE);
      if (w_next == GRANT0)
        r_mux_sel <= 1'b0;
      else if (w_next == GRANT1)
        r_mux_sel <= 1'b1;
      if (w_entry) begin
        r_hold_cnt <= '0;
        r_last_gnt <= (w_next == GRANT1);
      end else if (w_in_grant && (r_hold_cnt != HoldLimit)) begin
        r_hold_cnt <= r_hold_cnt + 8'd1;
      end
    end
  end

  assign Gnt_0     = r_gnt0;
  assign Gnt_1     = r_gnt1;
  assign MuxSel    = r_mux_sel;
  assign MuxEnable = r_mux_en;
  assign Busy      = r_busy;

endmodule

// File: tb/tb_bus_arbiter_2.sv
// Directed and randomised checks of bus_arbiter_2 with MaxHold = 4.
// Output vector order is {Gnt_0, Gnt_1, MuxSel, MuxEnable, Busy}.
module tb_bus_arbiter_2;

  localparam int unsigned MH = 4;

  logic Clock = 1'b0;
  logic nReset = 1'b1;
  logic Req_0 = 1'b0;
  logic Req_1 = 1'b0;
  logic Gnt_0, Gnt_1, MuxSel, MuxEnable, Busy;
  logic [4:0] obs;

  int checks = 0;
  int errors = 0;

  bus_arbiter_2 #(.MaxHold(MH)) dut (
    .Clock(Clock), .nReset(nReset), .Req_0(Req_0), .Req_1(Req_1),
    .Gnt_0(Gnt_0), .Gnt_1(Gnt_1), .MuxSel(MuxSel), .MuxEnable(MuxEnable), .Busy(Busy)
  );

  assign obs = {Gnt_0, Gnt_1, MuxSel, MuxEnable, Busy};

  always #5 Clock = ~Clock;

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset;
    #1 nReset = 1'b0;
    #1;
    checks++; if (obs !== 5'b00000) begin errors++; $display("FAIL reset_outputs: got %b expected %b", obs, 5'b00000); end
    @(negedge Clock);
    nReset = 1'b1;
    tick();
    checks++; if (obs !== 5'b00000) begin errors++; $display("FAIL reset_idle_after_release: got %b expected %b", obs, 5'b00000); end
  endtask

  task automatic test_contention;
    Req_0 = 1'b1; Req_1 = 1'b1;
    tick();
    checks++; if (obs !== 5'b10011) begin errors++; $display("FAIL contention_first_g0: got %b expected %b", obs, 5'b10011); end
    Req_0 = 1'b0;
    tick();
    checks++; if (obs !== 5'b00001) begin errors++; $display("FAIL contention_turn: got %b expected %b", obs, 5'b00001); end
    tick();
    checks++; if (obs !== 5'b01111) begin errors++; $display("FAIL contention_g1: got %b expected %b", obs, 5'b01111); end
    Req_1 = 1'b0;
    tick();
    checks++; if (obs !== 5'b00101) begin errors++; $display("FAIL contention_turn_sel_held: got %b expected %b", obs, 5'b00101); end
    tick();
    checks++; if (obs !== 5'b00100) begin errors++; $display("FAIL contention_idle_sel_held: got %b expected %b", obs, 5'b00100); end
  endtask

  task automatic test_preempt;
    Req_0 = 1'b1;
    tick();
    checks++; if (obs !== 5'b10011) begin errors++; $display("FAIL preempt_g0_c1: got %b expected %b", obs, 5'b10011); end
    Req_1 = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      tick();
      checks++; if (obs !== 5'b10011) begin errors++; $display("FAIL preempt_g0_c%0d: got %b expected %b", i, obs, 5'b10011); end
    end
    tick();
    checks++; if (obs !== 5'b00001) begin errors++; $display("FAIL preempt_turn0: got %b expected %b", obs, 5'b00001); end
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++; if (obs !== 5'b01111) begin errors++; $display("FAIL preempt_g1_c%0d: got %b expected %b", i, obs, 5'b01111); end
    end
    tick();
    checks++; if (obs !== 5'b00101) begin errors++; $display("FAIL preempt_turn1: got %b expected %b", obs, 5'b00101); end
    tick();
    checks++; if (obs !== 5'b10011) begin errors++; $display("FAIL preempt_regrant_g0: got %b expected %b", obs, 5'b10011); end
    Req_0 = 1'b0; Req_1 = 1'b0;
    tick();
    checks++; if (obs !== 5'b00001) begin errors++; $display("FAIL preempt_final_turn: got %b expected %b", obs, 5'b00001); end
    tick();
    checks++; if (obs !== 5'b00000) begin errors++; $display("FAIL preempt_final_idle: got %b expected %b", obs, 5'b00000); end
  endtask

  task automatic test_hold_saturate;
    Req_1 = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++; if (obs !== 5'b01111) begin errors++; $display("FAIL saturate_g1_c%0d: got %b expected %b", i, obs, 5'b01111); end
    end
    checks++; if (dut.r_hold_cnt !== 8'd3) begin errors++; $display("FAIL saturate_holdcnt: got %0d expected %0d", dut.r_hold_cnt, 3); end
    Req_1 = 1'b0;
    tick();
    checks++; if (obs !== 5'b00101) begin errors++; $display("FAIL saturate_turn: got %b expected %b", obs, 5'b00101); end
    tick();
    checks++; if (obs !== 5'b00100) begin errors++; $display("FAIL saturate_idle: got %b expected %b", obs, 5'b00100); end
  endtask

  task automatic test_turn_fresh;
    Req_0 = 1'b1;
    tick();
    checks++; if (obs !== 5'b10011) begin errors++; $display("FAIL fresh_g0: got %b expected %b", obs, 5'b10011); end
    Req_0 = 1'b0;
    tick();
    checks++; if (obs !== 5'b00001) begin errors++; $display("FAIL fresh_turn: got %b expected %b", obs, 5'b00001); end
    Req_0 = 1'b1;
    tick();
    checks++; if (obs !== 5'b10011) begin errors++; $display("FAIL fresh_regrant_g0: got %b expected %b", obs, 5'b10011); end
    Req_0 = 1'b0;
    tick();
    checks++; if (obs !== 5'b00001) begin errors++; $display("FAIL fresh_turn2: got %b expected %b", obs, 5'b00001); end
    tick();
    checks++; if (obs !== 5'b00000) begin errors++; $display("FAIL fresh_idle: got %b expected %b", obs, 5'b00000); end
  endtask

  task automatic test_release_and_preempt;
    Req_0 = 1'b1;
    tick();
    checks++; if (obs !== 5'b10011) begin errors++; $display("FAIL relpre_g0_c1: got %b expected %b", obs, 5'b10011); end
    Req_1 = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      tick();
      checks++; if (obs !== 5'b10011) begin errors++; $display("FAIL relpre_g0_c%0d: got %b expected %b", i, obs, 5'b10011); end
    end
    Req_0 = 1'b0;
    tick();
    checks++; if (obs !== 5'b00001) begin errors++; $display("FAIL relpre_turn: got %b expected %b", obs, 5'b00001); end
    tick();
    checks++; if (obs !== 5'b01111) begin errors++; $display("FAIL relpre_g1: got %b expected %b", obs, 5'b01111); end
    Req_1 = 1'b0;
    tick();
    checks++; if (obs !== 5'b00101) begin errors++; $display("FAIL relpre_turn2: got %b expected %b", obs, 5'b00101); end
    tick();
    checks++; if (obs !== 5'b00100) begin errors++; $display("FAIL relpre_idle: got %b expected %b", obs, 5'b00100); end
  endtask

  task automatic test_reset_mid_grant;
    Req_1 = 1'b1;
    tick();
    checks++; if (obs !== 5'b01111) begin errors++; $display("FAIL midrst_g1: got %b expected %b", obs, 5'b01111); end
    #2 nReset = 1'b0;
    #1;
    checks++; if (obs !== 5'b00000) begin errors++; $display("FAIL midrst_async_drop: got %b expected %b", obs, 5'b00000); end
    Req_0 = 1'b1;
    @(negedge Clock);
    nReset = 1'b1;
    tick();
    checks++; if (obs !== 5'b10011) begin errors++; $display("FAIL midrst_first_g0: got %b expected %b", obs, 5'b10011); end
    Req_0 = 1'b0; Req_1 = 1'b0;
    tick();
    checks++; if (obs !== 5'b00001) begin errors++; $display("FAIL midrst_turn: got %b expected %b", obs, 5'b00001); end
    tick();
    checks++; if (obs !== 5'b00000) begin errors++; $display("FAIL midrst_idle: got %b expected %b", obs, 5'b00000); end
  endtask

  task automatic test_random;
    int rem0 = 0, rem1 = 0, wait0 = 0, wait1 = 0;
    logic p_g0, p_g1, p_busy, p_r0, p_r1;
    p_g0 = Gnt_0; p_g1 = Gnt_1; p_busy = Busy; p_r0 = Req_0; p_r1 = Req_1;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      tick();
      checks++; if (Gnt_0 && Gnt_1) begin errors++; $display("FAIL rand_exclusive cyc %0d: got %b%b expected not both 1", cyc, Gnt_0, Gnt_1); end
      checks++; if (MuxEnable !== (Gnt_0 | Gnt_1)) begin errors++; $display("FAIL rand_mux_enable cyc %0d: got %b expected %b", cyc, MuxEnable, Gnt_0 | Gnt_1); end
      checks++; if ((p_g0 && Gnt_1) || (p_g1 && Gnt_0)) begin errors++; $display("FAIL rand_turn_gap cyc %0d: got prev %b%b now %b%b expected TURN between", cyc, p_g0, p_g1, Gnt_0, Gnt_1); end
      if (!p_busy && (p_r0 || p_r1)) begin
        checks++; if (!(Gnt_0 || Gnt_1)) begin errors++; $display("FAIL rand_latency cyc %0d: got no grant expected grant one cycle after request", cyc); end
      end
      wait0 = (p_r0 && !p_g0) ? wait0 + 1 : 0;
      wait1 = (p_r1 && !p_g1) ? wait1 + 1 : 0;
      checks++; if ((wait0 > int'(MH) + 2) || (wait1 > int'(MH) + 2)) begin errors++; $display("FAIL rand_wait_bound cyc %0d: got %0d/%0d expected <= %0d", cyc, wait0, wait1, int'(MH) + 2); end
      if (Req_0) begin
        if (Gnt_0) begin rem0--; if (rem0 == 0) Req_0 = 1'b0; end
      end else if ($urandom_range(0, 3) == 0) begin
        Req_0 = 1'b1; rem0 = int'($urandom_range(1, 8));
      end
      if (Req_1) begin
        if (Gnt_1) begin rem1--; if (rem1 == 0) Req_1 = 1'b0; end
      end else if ($urandom_range(0, 3) == 0) begin
        Req_1 = 1'b1; rem1 = int'($urandom_range(1, 8));
      end
      p_g0 = Gnt_0; p_g1 = Gnt_1; p_busy = Busy; p_r0 = Req_0; p_r1 = Req_1;
    end
    Req_0 = 1'b0; Req_1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_contention();
    test_preempt();
    test_hold_saturate();
    test_turn_fresh();
    test_release_and_preempt();
    test_reset_mid_grant();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_2.md
BUS_ARBITER_2 -- requirements
Module: bus_arbiter_2

Interface
REQ-001 Parameter MaxHold, default 8: maximum grant length in cycles while the other requester waits; legal range 2..255.
REQ-002 Clock  input  1  single system clock; all state updates on the rising edge.
REQ-003 nReset  input  1  reset, asynchronous, active-low.
REQ-004 Req_0  input  1  bus request from requester 0; held high for the whole transfer.
REQ-005 Req_1  input  1  bus request from requester 1; held high for the whole transfer.
REQ-006 Gnt_0  output  1  bus granted to requester 0, registered.
REQ-007 Gnt_1  output  1  bus granted to requester 1, registered.
REQ-008 MuxSel  output  1  select for the 2:1 bus multiplexer, registered; 0 = requester 0, 1 = requester 1.
REQ-009 MuxEnable  output  1  enable for the 2:1 bus multiplexer, registered; high only while a grant is active.
REQ-010 Busy  output  1  high in any state other than IDLE.

Function
REQ-011 The block SHALL implement the FSM states IDLE, GRANT0, GRANT1 and TURN.
REQ-012 Outputs SHALL be decoded from registered state only: Gnt_0 = GRANT0, Gnt_1 = GRANT1, MuxEnable = GRANT0 or GRANT1.
REQ-013 In GRANT0 MuxSel SHALL be 0 and in GRANT1 it SHALL be 1; in IDLE and TURN it SHALL hold its last value.
REQ-014 IDLE and TURN SHALL arbitrate at each rising edge as follows:
- only Req_0 high: go to GRANT0;
- only Req_1 high: go to GRANT1;
- both high: grant the requester not recorded in LastGnt;
- neither high: go to or stay in IDLE.
REQ-015 Grant latency SHALL be exactly one cycle: a request sampled high in IDLE gives the grant in the next cycle.
REQ-016 LastGnt SHALL be a 1-bit register, updated to n on every entry into GRANTn.
REQ-017 HoldCnt SHALL be an 8-bit counter with the following behaviour:
- cleared to 0 on entry into any GRANT state;
- incremented each cycle spent in a GRANT state;
- saturates at MaxHold-1.
REQ-018 GRANTn SHALL go to TURN when Req_n is sampled low (release).
REQ-019 GRANTn SHALL go to TURN when HoldCnt = MaxHold-1 and the other request is sampled high (preemption).
REQ-020 In GRANTn with Req_n high and no preemption, the block SHALL stay in GRANTn.
REQ-021 With the other request low, HoldCnt SHALL saturate and the grant SHALL continue indefinitely.
REQ-022 TURN SHALL last exactly one cycle with no grant, so that two requesters never drive the bus in consecutive cycles.
REQ-023 Simultaneous release and preemption SHALL be treated as a release, with the same single TURN cycle.
REQ-024 A preempted requester that keeps Req_n high SHALL be regranted only after the other requester's grant ends, following round-robin via LastGnt.
REQ-025 Gnt_0 and Gnt_1 SHALL never be high in the same cycle.
REQ-026 A requester dropping and reasserting its request within TURN SHALL be treated as a fresh request.

Reset
REQ-027 nReset low SHALL immediately, without waiting for a clock edge, force the following values:
- state = IDLE;
- Gnt_0 = 0, Gnt_1 = 0;
- MuxSel = 0, MuxEnable = 0, Busy = 0;
- HoldCnt = 0;
- LastGnt = 1, so requester 0 wins the first contention.
REQ-028 Reset asserted mid-grant SHALL drop the grant asynchronously and SHALL NOT produce a TURN cycle.
REQ-029 The first arbitration SHALL occur at the first rising edge after nReset is released.

Verification
REQ-030 Reset, then Req_0=1 and Req_1=1 together: cycle 1 Gnt_0=1, MuxSel=0, MuxEnable=1; Req_0 dropped -> one TURN cycle with MuxEnable=0 -> Gnt_1=1, MuxSel=1.
REQ-031 MaxHold=4, Req_0 held high, Req_1 raised one cycle after Gnt_0: Gnt_0 high for exactly 4 cycles -> 1 TURN cycle -> Gnt_1=1.
REQ-032 Req_1 alone held high for 20 cycles: Gnt_1 high continuously from cycle 1 to cycle 20; no preemption, HoldCnt stuck at MaxHold-1.
REQ-033 nReset pulsed low mid-GRANT1: Gnt_1, MuxEnable and MuxSel go to 0 before the next edge; after release with Req_0=Req_1=1, Gnt_0 is granted first.
REQ-034 Req_0 release and preemption on the same edge: exactly one TURN cycle, then Gnt_1; a bus assertion checker reports no cycle with Gnt_0=Gnt_1=1 and no cycle with MuxEnable=1 in TURN.
REQ-035 A random request stream over 10000 cycles: checker confirms REQ-025 holds, the one-cycle grant latency holds, and the wait between request and grant is never longer than MaxHold+2 cycles.
